// File: rtl/kalman_filter_mc.sv
// kalman_filter_mc -- multi-channel scalar Kalman filter for the gyro path.
// One shared predict / gain / update datapath serves N_CH independent
// channels. Each channel keeps its own (x, P) pair. The gain is produced by
// a restoring divider that emits one quotient bit per cycle.
//
// Ports
//   i_clk, i_rst_n      clock, async active-low reset
//   i_meas_vld/o_ready  input handshake (accept on vld & ready)
//   i_meas_ch, i_meas   channel index and signed measurement z
//   i_kal_Q, i_kal_R    process / measurement noise, captured at accept
//   i_ch_clr            per-channel state clear bitmask (level, every cycle)
//   o_vld               one-cycle result strobe
//   o_ch, x_out, p_out  channel, filtered estimate, updated covariance

// Per-channel state pair. A clear always wins over a write-back.
module kalman_ch_state #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr,
  input  logic [DATA_W-1:0] x_d,
  input  logic [DATA_W-1:0] p_d,
  output logic [DATA_W-1:0] x_q,
  output logic [DATA_W-1:0] p_q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      p_q <= '0;
    end else if (clr) begin
      x_q <= '0;
      p_q <= '0;
    end else if (wr) begin
      x_q <= x_d;
      p_q <= p_d;
    end
  end
endmodule

module kalman_filter_mc #(
  parameter int N_CH   = 3,
  parameter int MEAS_W = 14,
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_meas_vld,
  input  logic [CH_W-1:0]   i_meas_ch,
  input  logic [MEAS_W-1:0] i_meas,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_kal_Q,
  input  logic [DATA_W-1:0] i_kal_R,
  input  logic [N_CH-1:0]   i_ch_clr,
  output logic              o_vld,
  output logic [CH_W-1:0]   o_ch,
  output logic [DATA_W-1:0] x_out,
  output logic [DATA_W-1:0] p_out
);
  localparam int CNT_W = $clog2(FRAC_W + 1);
  localparam int EK_W  = DATA_W + FRAC_W + 3;  // signed e * K
  localparam int PK_W  = DATA_W + FRAC_W;      // Pp * K, K <= 2^FRAC_W

  typedef enum logic [2:0] {S_IDLE, S_PRED, S_DIV, S_UPD, S_WB} state_t;
  state_t state;

  // Captured transaction
  logic [CH_W-1:0]          ch_r;
  logic signed [DATA_W:0]   z_r;
  logic [DATA_W-1:0]        q_r, r_r, x_r, p_r;
  logic                     clr_hit;
  // Datapath
  logic [DATA_W-1:0]        pp_r;
  logic [DATA_W:0]          d_r;
  logic [DATA_W+1:0]        rem_r;
  logic [FRAC_W:0]          k_r;
  logic [CNT_W-1:0]         div_cnt;
  logic [DATA_W-1:0]        x_new_r, p_new_r;

  logic [N_CH-1:0][DATA_W-1:0] x_q, p_q;

  assign o_ready = (state == S_IDLE);

  logic ch_ok;
  assign ch_ok = (int'(i_meas_ch) < N_CH);

  // Predict: Pp = sat(P + Q), D = Pp + R at one extra bit
  logic [DATA_W:0]   pq_sum, d_sum;
  logic [DATA_W-1:0] pp_sat;
  assign pq_sum = {1'b0, p_r} + {1'b0, q_r};
  assign pp_sat = pq_sum[DATA_W] ? '1 : pq_sum[DATA_W-1:0];
  assign d_sum  = {1'b0, pp_sat} + {1'b0, r_r};

  // Restoring divide of Pp * 2^FRAC_W by D. Since Pp <= D the top quotient
  // bit is just (Pp >= D), so the first step compares without shifting.
  logic [DATA_W+1:0] div_cur, div_d;
  logic              div_ge;
  assign div_cur = (div_cnt == '0) ? rem_r : {rem_r[DATA_W:0], 1'b0};
  assign div_d   = {1'b0, d_r};
  assign div_ge  = (div_cur >= div_d);

  // Update. D == 0 implies Pp == 0; the divider would return all ones there.
  logic [FRAC_W:0]        k_eff;
  logic signed [DATA_W:0] e_s;
  logic signed [EK_W-1:0] ek_w;
  logic [PK_W-1:0]        pk_w;
  assign k_eff = (d_r == '0) ? '0 : k_r;
  assign e_s   = z_r - $signed({x_r[DATA_W-1], x_r});
  assign ek_w  = EK_W'(e_s) * $signed(EK_W'(k_eff));
  assign pk_w  = PK_W'(pp_r) * PK_W'(k_eff);

  logic wb_wr;
  assign wb_wr = (state == S_WB) && !clr_hit;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    kalman_ch_state #(.DATA_W(DATA_W)) u_st (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .clr   (i_ch_clr[c]),
      .wr    (wb_wr && (ch_r == CH_W'(c))),
      .x_d   (x_new_r),
      .p_d   (p_new_r),
      .x_q   (x_q[c]),
      .p_q   (p_q[c])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      ch_r    <= '0;
      z_r     <= '0;
      q_r     <= '0;
      r_r     <= '0;
      x_r     <= '0;
      p_r     <= '0;
      clr_hit <= 1'b0;
      pp_r    <= '0;
      d_r     <= '0;
      rem_r   <= '0;
      k_r     <= '0;
      div_cnt <= '0;
      x_new_r <= '0;
      p_new_r <= '0;
      o_vld   <= 1'b0;
      o_ch    <= '0;
      x_out   <= '0;
      p_out   <= '0;
    end else begin
      o_vld <= 1'b0;
      // A clear seen anywhere while in flight cancels the write-back.
      if (state != S_IDLE && i_ch_clr[ch_r]) clr_hit <= 1'b1;
      case (state)
        S_IDLE: begin
          // Out-of-range channels are swallowed without leaving IDLE.
          if (i_meas_vld && ch_ok) begin
            ch_r    <= i_meas_ch;
            z_r     <= (DATA_W+1)'($signed(i_meas));
            q_r     <= i_kal_Q;
            r_r     <= i_kal_R;
            x_r     <= x_q[i_meas_ch];
            p_r     <= p_q[i_meas_ch];
            clr_hit <= i_ch_clr[i_meas_ch];
            state   <= S_PRED;
          end
        end
        S_PRED: begin
          pp_r    <= pp_sat;
          d_r     <= d_sum;
          rem_r   <= {2'b00, pp_sat};
          k_r     <= '0;
          div_cnt <= '0;
          state   <= S_DIV;
        end
        S_DIV: begin
          rem_r   <= div_ge ? (div_cur - div_d) : div_cur;
          k_r     <= {k_r[FRAC_W-1:0], div_ge};
          div_cnt <= div_cnt + 1'b1;
          if (div_cnt == CNT_W'(FRAC_W)) state <= S_UPD;
        end
        S_UPD: begin
          x_new_r <= x_r + DATA_W'(ek_w >>> FRAC_W);
          p_new_r <= pp_r - DATA_W'(pk_w >> FRAC_W);
          state   <= S_WB;
        end
        S_WB: begin
          o_vld <= 1'b1;
          o_ch  <= ch_r;
          x_out <= x_new_r;
          p_out <= p_new_r;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_kalman_filter_mc.sv
// Scoreboard bench for kalman_filter_mc: the driver pushes hand-computed
// results at accept time; the monitor pops and compares on every o_vld.
module tb_kalman_filter_mc;
  localparam int N_CH = 3, MEAS_W = 14, DATA_W = 32, FRAC_W = 16, CH_W = 2;
  localparam int LAT = FRAC_W + 4;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_meas_vld = 1'b0;
  logic [CH_W-1:0]   i_meas_ch = '0;
  logic [MEAS_W-1:0] i_meas = '0;
  logic              o_ready;
  logic [DATA_W-1:0] i_kal_Q = '0, i_kal_R = '0;
  logic [N_CH-1:0]   i_ch_clr = '0;
  logic              o_vld;
  logic [CH_W-1:0]   o_ch;
  logic [DATA_W-1:0] x_out, p_out;

  kalman_filter_mc #(.N_CH(N_CH), .MEAS_W(MEAS_W), .DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_meas_vld(i_meas_vld), .i_meas_ch(i_meas_ch),
    .i_meas(i_meas), .o_ready(o_ready), .i_kal_Q(i_kal_Q), .i_kal_R(i_kal_R),
    .i_ch_clr(i_ch_clr), .o_vld(o_vld), .o_ch(o_ch), .x_out(x_out), .p_out(p_out)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] p;
    int                acc;
  } exp_t;
  exp_t sb[$];

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor
  initial begin
    forever begin
      exp_t e;
      @(negedge i_clk);
      if (i_rst_n && o_vld) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_vld: ch=%0d x=0x%0h p=0x%0h, expected no result", o_ch, x_out, p_out);
        end else begin
          e = sb.pop_front();
          chk("o_ch", 64'(o_ch), 64'(e.ch));
          chk("x_out", 64'(x_out), 64'(e.x));
          chk("p_out", 64'(p_out), 64'(e.p));
          chk("latency", 64'(cyc - e.acc), 64'(LAT));
        end
      end
    end
  end

  // Drive one measurement; returns at the negedge after the accepting edge.
  task automatic send(input int ch, input int z, input logic [31:0] q, input logic [31:0] r,
                      input bit expect_out, input logic [31:0] ex, input logic [31:0] ep);
    int n = 0;
    @(negedge i_clk);
    i_meas_ch = ch[CH_W-1:0];
    i_meas = z[MEAS_W-1:0];
    i_kal_Q = q;
    i_kal_R = r;
    i_meas_vld = 1'b1;
    while (!o_ready && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL accept_timeout: o_ready=%0b, expected 1", o_ready);
    end else if (expect_out) begin
      sb.push_back('{ch[CH_W-1:0], ex, ep, cyc + 1});
    end
    @(negedge i_clk);
    i_meas_vld = 1'b0;
    // Noise inputs change after accept; the update in flight must not care.
    i_kal_Q = 32'hDEAD_BEEF;
    i_kal_R = 32'h1234_5678;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !o_ready) && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
    end
  endtask

  initial begin
    int acc_n;
    int acc_cyc[2];
    int n;
    logic [31:0] cont_x[2];
    logic [31:0] cont_p[2];
    cont_x[0] = -30; cont_p[0] = 3;
    cont_x[1] = -49; cont_p[1] = 4;

    // Reset values
    repeat (3) @(negedge i_clk);
    chk("rst_o_ready", 64'(o_ready), 64'd1);
    chk("rst_o_vld", 64'(o_vld), 64'd0);
    chk("rst_x_out", 64'(x_out), 64'd0);
    chk("rst_p_out", 64'(p_out), 64'd0);
    chk("rst_o_ch", 64'(o_ch), 64'd0);
    i_rst_n = 1'b1;
    repeat (30) @(negedge i_clk);

    // Single update and channel independence
    send(0, 1000, 1, 100, 1, 9, 1);       // K=648
    drain();
    send(1, -500, 1, 100, 1, -5, 1);
    drain();
    send(0, 1000, 1, 100, 1, 28, 2);      // K=1285
    drain();
    send(1, -500, 1, 100, 1, -15, 2);     // ch1 resumed from (-5,1)
    drain();

    // Gain bounds on fresh ch2
    send(2, 777, 1, 0, 1, 777, 0);        // K=65536
    drain();
    send(2, 100, 0, 0, 1, 777, 0);        // D=0 -> K=0
    drain();

    // Saturation: Pp clamps to all ones, K=32768
    send(2, -1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, -112, 32'h8000_0000);
    drain();
    send(2, -1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, -556, 32'h8000_0000);
    drain();

    // Valid held high: back-to-back accepts on ch1
    @(negedge i_clk);
    i_meas_ch = 2'd1;
    i_meas = 14'h3E0C;                     // -500
    i_kal_Q = 1;
    i_kal_R = 100;
    i_meas_vld = 1'b1;
    acc_n = 0;
    n = 0;
    while (acc_n < 2 && n < 100) begin
      if (o_ready) begin
        acc_cyc[acc_n] = cyc + 1;
        sb.push_back('{2'd1, cont_x[acc_n], cont_p[acc_n], cyc + 1});
        acc_n++;
      end
      @(negedge i_clk);
      n++;
    end
    i_meas_vld = 1'b0;
    if (acc_n < 2) begin
      tests++; fails++;
      $display("FAIL cont_accept_timeout: %0d accepts, expected 2", acc_n);
    end else begin
      chk("accept_spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'(FRAC_W + 5));
    end
    drain();

    // Clear during DIV: result still emitted, state wiped
    send(0, 1000, 1, 100, 1, 56, 3);
    repeat (5) @(negedge i_clk);
    i_ch_clr = 3'b001;
    @(negedge i_clk);
    i_ch_clr = 3'b000;
    drain();
    send(0, 1000, 1, 100, 1, 9, 1);
    drain();

    // Out-of-range channel is dropped
    send(3, 50, 1, 100, 0, 0, 0);
    chk("oor_ready", 64'(o_ready), 64'd1);
    repeat (30) @(negedge i_clk);

    // Reset during DIV aborts and clears state
    send(1, -500, 1, 100, 0, 0, 0);
    repeat (6) @(negedge i_clk);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    chk("abort_o_vld", 64'(o_vld), 64'd0);
    chk("abort_x_out", 64'(x_out), 64'd0);
    chk("abort_p_out", 64'(p_out), 64'd0);
    chk("abort_o_ready", 64'(o_ready), 64'd1);
    i_rst_n = 1'b1;
    repeat (30) @(negedge i_clk);
    send(1, -500, 1, 100, 1, -5, 1);      // ch1 back to (0,0)
    drain();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/kalman_filter_mc.md
# kalman_filter_mc

Multi-channel, parametrised scalar Kalman filter for the gyro measurement path, the successor of `Kalman_filter_SM`. It filters up to N_CH independent measurement streams, for example several gyro axes, with one shared arithmetic datapath and one state register pair per channel. Each update runs predict, gain and update through an iterative divider, with a valid/ready input handshake and a one-cycle valid strobe on the result. It sits between the demodulated measurement source and the output/register interface.

## Interface
- N_CH, 3, number of channels (≥1); channel index width CH_W = max(1, clog2(N_CH))
- MEAS_W, 14, signed measurement width
- DATA_W, 32, width of state x (signed), P, Q, R (unsigned)
- FRAC_W, 16, fractional bits of gain K
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_meas_vld  in  1  measurement valid
- i_meas_ch  in  CH_W  channel of measurement
- i_meas  in  MEAS_W  signed measurement z
- o_ready  out  1  block idle, can accept
- i_kal_Q  in  DATA_W  process noise, unsigned
- i_kal_R  in  DATA_W  measurement noise, unsigned
- i_ch_clr  in  N_CH  per-channel state clear, bitmask, level-sampled each cycle
- o_vld  out  1  one-cycle result strobe
- o_ch  out  CH_W  channel of result
- x_out  out  DATA_W  signed filtered estimate
- p_out  out  DATA_W  updated error covariance

## Operation
- **Accept rule:** a measurement is accepted on an edge where i_meas_vld=1 and o_ready=1. i_meas, i_meas_ch, Q and R are captured at that edge. Q/R changes after accept do not affect the update in flight.
- **Out-of-range channel:** i_meas_ch ≥ N_CH is accepted and discarded. No state change, no o_vld, o_ready stays 1.
- **FSM:** IDLE → PRED (1) → DIV (FRAC_W+1) → UPD (1) → WB (1) → IDLE. o_ready = (state==IDLE).
- **PRED:** Pp = P + Q, saturating at 2^DATA_W−1. D = Pp + R, computed at DATA_W+1 bits.
- **DIV:** K = floor(Pp·2^FRAC_W / D), restoring divider, one quotient bit per cycle, K width FRAC_W+1. If D==0, K=0. K ≤ 2^FRAC_W always.
- **UPD:**
  - e = sext(z) − x, DATA_W+1 bits.
  - x' = x + ((e·K) >>> FRAC_W), arithmetic shift, i.e. floor. x' always lies between x and z, so there is no overflow.
  - P' = Pp − ((Pp·K) >> FRAC_W), so P' ≥ 0.
- **WB:** x', P' are written to the channel's state. x_out=x', p_out=P', o_ch=channel, o_vld=1 for this cycle only. Outputs hold their values until the next WB.
- **Clear:**
  - i_ch_clr[c]=1 sets x[c]=0, P[c]=0 on that edge.
  - If channel c is in flight, the clear takes effect and the WB write for c is suppressed. The clear takes priority even when it coincides with WB.
  - o_vld and outputs for that result are still produced.
- Channels never interact; only the datapath is shared.

## Timing
- Reset values: x_out=0, p_out=0, o_ch=0, o_vld=0, state=IDLE (o_ready=1), all x[c]=0, all P[c]=0.
- Latency: accepted at edge t, o_vld is high in the cycle after edge t+FRAC_W+4, which is 20 cycles for the default parameters.
- o_ready deasserts the cycle after accept and reasserts the cycle after o_vld. Throughput is one update per FRAC_W+5 cycles. i_meas_vld held while busy is ignored, not queued.
- A measurement may be accepted in the same cycle o_ready returns.
- Reset asserted mid-operation aborts immediately. No o_vld is issued and all state returns to reset values.

## Test plan
- **Reset:** hold i_rst_n=0 → all outputs at reset values, o_ready=1. Release with no stimulus → o_vld never asserts.
- **Single update:** Q=1, R=100, ch0 z=1000 → K=648, o_vld exactly 20 cycles after accept, x_out=9, p_out=1, o_ch=0.
- **Channel independence:** continue from the single-update case.
  - ch1 z=−500 → x_out=−5, p_out=1.
  - Then ch0 z=1000 → K=1285, x_out=28, p_out=2; ch1 state unchanged.
- **Gain bounds:**
  - R=0, Q=1, fresh channel, z=777 → K=65536, x_out=777, p_out=0.
  - Then Q=0, R=0 on that channel → D=0, K=0, x_out stays 777.
- **Saturation:** Q=0xFFFFFFFF, R=0xFFFFFFFF, two updates → Pp saturates at 0xFFFFFFFF with no wrap, and p_out is monotonic and ≤ 0xFFFFFFFF.
- **Handshake / clear / abort:**
  - i_meas_vld held high continuously → accepts spaced FRAC_W+5 cycles apart.
  - i_ch_clr[0] pulsed during DIV of ch0 → o_vld still asserts, and the next ch0 update starts from x=0, P=0.
  - Channel index 3 with N_CH=3 → no o_vld.
  - Reset during DIV → no o_vld, outputs 0.
